// File: rtl/rgb888_ycbcr444.sv
// RGB888 -> YCbCr444 (BT.601 full range, 8-bit fixed point), 3-clk pipeline,
// with vsync/href delay matching and per-frame input geometry check.
// Optional build macro: RGB2YCBCR_ROUND_EN (round-to-nearest + saturation).
module rgb888_ycbcr444 #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic [7:0] post_img_Y,
  output logic [7:0] post_img_Cb,
  output logic [7:0] post_img_Cr,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned PW = 16;  // product width
  localparam int unsigned SW = 17;  // sum width
  localparam int unsigned CW = 11;  // counter width
  localparam int unsigned DW = 3;   // sync delay depth

`ifdef RGB2YCBCR_ROUND_EN
  localparam logic [SW-1:0] RND = 17'd128;
`else
  localparam logic [SW-1:0] RND = 17'd0;
`endif
  localparam logic [SW-1:0] OFS = 17'd32768;
  localparam logic [CW-1:0] CNT_MAX = 11'h7FF;

  // stage 1: products, index order 77R 150G 29B 43R 85G 128B 128R 107G 21B
  logic [PW-1:0] p_d [9];
  logic [PW-1:0] p_q [9];
  // stage 2: sums
  logic [SW-1:0] ysum_d, cbsum_d, crsum_d;
  logic [SW-1:0] ysum_q, cbsum_q, crsum_q;
  // stage 3: saturated outputs
  logic [7:0]    y_d, cb_d, cr_d;
  logic [7:0]    y_q, cb_q, cr_q;
  // sync delay lines; bit 0 also serves as the previous input sample
  logic [DW-1:0] vs_sr_q, hs_sr_q;
  // geometry check state
  logic [CW-1:0] pix_cnt_d, pix_cnt_q;
  logic [CW-1:0] line_cnt_d, line_cnt_q;
  logic          line_err_d, line_err_q;
  logic          frame_done_d, frame_done_q;
  logic          frame_err_d, frame_err_q;
  logic          vs_rise, vs_fall, hs_fall;
  logic          unused_lsb;

  // Stage 1 products from the raw input pixel
  always_comb begin
    p_d[0] = PW'(per_img_red)   * 16'd77;
    p_d[1] = PW'(per_img_green) * 16'd150;
    p_d[2] = PW'(per_img_blue)  * 16'd29;
    p_d[3] = PW'(per_img_red)   * 16'd43;
    p_d[4] = PW'(per_img_green) * 16'd85;
    p_d[5] = PW'(per_img_blue)  * 16'd128;
    p_d[6] = PW'(per_img_red)   * 16'd128;
    p_d[7] = PW'(per_img_green) * 16'd107;
    p_d[8] = PW'(per_img_blue)  * 16'd21;
  end

  // Stage 2 sums; offset added before subtracting so nothing goes negative
  always_comb begin
    ysum_d  = SW'(p_q[0]) + SW'(p_q[1]) + SW'(p_q[2]) + RND;
    cbsum_d = SW'(p_q[5]) + OFS - SW'(p_q[3]) - SW'(p_q[4]) + RND;
    crsum_d = SW'(p_q[6]) + OFS - SW'(p_q[7]) - SW'(p_q[8]) + RND;
  end

  // Stage 3 take the integer byte, saturating on carry into bit 16
  always_comb begin
    y_d  = ysum_q[16]  ? 8'hFF : ysum_q[15:8];
    cb_d = cbsum_q[16] ? 8'hFF : cbsum_q[15:8];
    cr_d = crsum_q[16] ? 8'hFF : crsum_q[15:8];
  end

  assign unused_lsb = ^{ysum_q[7:0], cbsum_q[7:0], crsum_q[7:0]};

  // Datapath and sync pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
      ysum_q  <= '0;
      cbsum_q <= '0;
      crsum_q <= '0;
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
      vs_sr_q <= '0;
      hs_sr_q <= '0;
    end else begin
      for (int i = 0; i < 9; i++) p_q[i] <= p_d[i];
      ysum_q  <= ysum_d;
      cbsum_q <= cbsum_d;
      crsum_q <= crsum_d;
      y_q     <= y_d;
      cb_q    <= cb_d;
      cr_q    <= cr_d;
      vs_sr_q <= {vs_sr_q[DW-2:0], per_frame_vsync};
      hs_sr_q <= {hs_sr_q[DW-2:0], per_frame_href};
    end
  end

  assign vs_rise = per_frame_vsync & ~vs_sr_q[0];
  assign vs_fall = ~per_frame_vsync & vs_sr_q[0];
  assign hs_fall = ~per_frame_href & hs_sr_q[0];

  // Geometry check next state; a line ending with the frame is counted first
  always_comb begin
    pix_cnt_d    = per_frame_href ? (pix_cnt_q + 11'd1) : '0;
    line_cnt_d   = line_cnt_q;
    line_err_d   = line_err_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    if (hs_fall && vs_sr_q[0]) begin
      if (pix_cnt_q != IMG_HDISP) line_err_d = 1'b1;
      if (line_cnt_q != CNT_MAX)  line_cnt_d = line_cnt_q + 11'd1;
    end
    if (vs_fall) begin
      frame_done_d = 1'b1;
      frame_err_d  = line_err_d | (line_cnt_d != IMG_VDISP);
      line_cnt_d   = '0;
      line_err_d   = 1'b0;
    end else if (vs_rise) begin
      line_cnt_d   = '0;
      line_err_d   = 1'b0;
    end
  end

  // Geometry check registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_err_q   <= line_err_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign post_frame_vsync = vs_sr_q[DW-1];
  assign post_frame_href  = hs_sr_q[DW-1];
  assign post_img_Y       = y_q;
  assign post_img_Cb      = cb_q;
  assign post_img_Cr      = cr_q;
  assign frame_done       = frame_done_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_rgb888_ycbcr444.sv
// Scoreboard bench for rgb888_ycbcr444. Frame geometry is scaled down
// (H x V) so complete frames fit in a short run.
module tb_rgb888_ycbcr444;

  localparam logic [10:0] H = 11'd40;
  localparam logic [10:0] V = 11'd30;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0, href = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic       post_vs, post_hs, fd, fe;
  logic [7:0] oy, ocb, ocr;

  pix_t exp_q[$];
  int   len_q[$];
  int   start_q[$];
  bit   ferr_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   exp_frames = 0, seen_frames = 0;
  int   gpix = 0;

  rgb888_ycbcr444 #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
    .post_frame_vsync(post_vs), .post_frame_href(post_hs),
    .post_img_Y(oy), .post_img_Cb(ocb), .post_img_Cr(ocr),
    .frame_done(fd), .frame_err(fe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BT.601 full-range conversion straight from the defining equations
  function automatic pix_t model(int r, int g, int b);
    int rnd, y, cb, cr;
    pix_t p;
    rnd = 0;
`ifdef RGB2YCBCR_ROUND_EN
    rnd = 128;
`endif
    y  = (77 * r + 150 * g + 29 * b + rnd) / 256;
    cb = (128 * b - 43 * r - 85 * g + 32768 + rnd) / 256;
    cr = (128 * r - 107 * g - 21 * b + 32768 + rnd) / 256;
    if (y > 255) y = 255;
    if (cb > 255) cb = 255;
    if (cr > 255) cr = 255;
    p.y = 8'(y); p.cb = 8'(cb); p.cr = 8'(cr);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit vs, bit hs, logic [7:0] r, logic [7:0] g, logic [7:0] b,
                       bit directed, pix_t dexp);
    tick();
    vsync = vs; href = hs; red = r; green = g; blue = b;
    if (hs) exp_q.push_back(directed ? dexp : model(int'(r), int'(g), int'(b)));
  endtask

  task automatic idle(int n, bit vs);
    for (int i = 0; i < n; i++)
      drive(vs, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, '0);
  endtask

  task automatic line(bit vs, int len, bit incr, bit fall_vs);
    logic [7:0] r;
    for (int i = 0; i < len; i++) begin
      r = incr ? 8'(gpix) : 8'($urandom);
      gpix++;
      drive(vs, 1'b1, r, 8'($urandom), 8'($urandom), 1'b0, '0);
      if (i == 0) start_q.push_back(cyc);
    end
    len_q.push_back(len);
    drive(fall_vs ? 1'b0 : vs, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, '0);
  endtask

  task automatic frame(int nlines, int short_line, int abort_line, bit same_fall,
                       bit exp_err, bit incr);
    bit last;
    if (abort_line < 0) begin
      ferr_q.push_back(exp_err);
      exp_frames++;
    end
    idle(4, 1'b1);
    for (int l = 0; l < nlines; l++) begin
      if (l == abort_line) begin
        tick();
        rst = 1'b1; vsync = 1'b0; href = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        idle(6, 1'b0);
        return;
      end
      last = same_fall && (l == nlines - 1);
      line(1'b1, (l == short_line) ? int'(H) - 1 : int'(H), incr, last);
      if (!last) idle(6, 1'b1);
    end
    idle(8, 1'b0);
  endtask

  task automatic pixel(logic [7:0] r, logic [7:0] g, logic [7:0] b, pix_t e);
    drive(1'b0, 1'b1, r, g, b, 1'b1, e);
    start_q.push_back(cyc);
    len_q.push_back(1);
    idle(5, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents output
  initial begin : monitor
    int   run;
    bit   prev_hs, prev_fd, last_err;
    pix_t e;
    run = 0; prev_hs = 0; prev_fd = 0; last_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; prev_hs = 0; prev_fd = 0; last_err = 0;
      end else begin
        if (post_hs) begin
          if (!prev_hs) begin
            check("line_start_expected", int'(start_q.size() > 0), 1);
            if (start_q.size() > 0) check("href_latency", cyc - start_q.pop_front(), 3);
          end
          run++;
          check("pixel_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Y", int'(oy), int'(e.y));
            check("Cb", int'(ocb), int'(e.cb));
            check("Cr", int'(ocr), int'(e.cr));
          end
        end else if (prev_hs) begin
          check("line_len_expected", int'(len_q.size() > 0), 1);
          if (len_q.size() > 0) check("post_href_len", run, len_q.pop_front());
          run = 0;
        end
        if (fd) begin
          seen_frames++;
          check("frame_done_width", int'(prev_fd), 0);
          check("frame_done_expected", int'(ferr_q.size() > 0), 1);
          if (ferr_q.size() > 0) check("frame_err", int'(fe), int'(ferr_q.pop_front()));
          last_err = fe;
        end else begin
          check("frame_err_held", int'(fe), int'(last_err));
        end
        prev_hs = post_hs;
        prev_fd = fd;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    pix_t c;
    // reset with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      tick();
      vsync = 1'($urandom); href = 1'($urandom);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      @(negedge clk);
      check("reset_outputs",
            int'({oy, ocb, ocr, post_vs, post_hs, fd, fe}), 0);
    end
    tick();
    rst = 1'b0; vsync = 1'b0; href = 1'b0;
    idle(4, 1'b0);

    // directed pixels with spec-given results
    c = '{8'd255, 8'd128, 8'd128}; pixel(8'd255, 8'd255, 8'd255, c);
    c = '{8'd0,   8'd128, 8'd128}; pixel(8'd0,   8'd0,   8'd0,   c);
`ifdef RGB2YCBCR_ROUND_EN
    c = '{8'd77,  8'd85,  8'd255}; pixel(8'd255, 8'd0,   8'd0,   c);
    c = '{8'd29,  8'd255, 8'd107}; pixel(8'd0,   8'd0,   8'd255, c);
`else
    c = '{8'd76,  8'd85,  8'd255}; pixel(8'd255, 8'd0,   8'd0,   c);
    c = '{8'd28,  8'd255, 8'd107}; pixel(8'd0,   8'd0,   8'd255, c);
`endif

    frame(int'(V), -1, -1, 1'b0, 1'b0, 1'b1);      // good frame, incrementing R
    frame(int'(V), 10, -1, 1'b0, 1'b1, 1'b0);      // short line
    frame(int'(V), -1, -1, 1'b0, 1'b0, 1'b0);      // recovers
    line(1'b0, int'(H) - 5, 1'b0, 1'b0);           // line outside vsync: passes, not counted
    idle(6, 1'b0);
    frame(int'(V) - 1, -1, -1, 1'b0, 1'b1, 1'b0);  // one line short
    frame(int'(V), -1, -1, 1'b1, 1'b0, 1'b0);      // href and vsync fall together
    frame(0, -1, -1, 1'b0, 1'b1, 1'b0);            // zero lines
    frame(int'(V), -1, 20, 1'b0, 1'b0, 1'b0);      // reset mid-frame, no report
    frame(int'(V), -1, -1, 1'b0, 1'b0, 1'b0);      // full frame after reset
    idle(12, 1'b0);

    check("pixels_drained", exp_q.size(), 0);
    check("lines_drained", len_q.size(), 0);
    check("starts_drained", start_q.size(), 0);
    check("frames_drained", ferr_q.size(), 0);
    check("frame_done_count", seen_frames, exp_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
